// File: rtl/haar_feature_sum_if.sv
// Stream bundle for haar_feature_sum: corner input, weight input and scaled feature output.
// master = producer/consumer side (fetch + comparator), slave = the summer itself.
interface haar_feature_sum_if #(
    parameter int W_DATA      = 18,
    parameter int W_WEIGHT    = 3,
    parameter int N_RECT_MAX  = 3,
    parameter int SCALE_SHIFT = 12
);
    localparam int W_NR   = $clog2(N_RECT_MAX + 1);
    localparam int W_DOUT = W_DATA + 2 + W_WEIGHT + W_NR + SCALE_SHIFT;

    logic                       din_valid;
    logic                       din_ready;
    logic [W_DATA-1:0]          din_data;
    logic                       din_last;
    logic                       weight_valid;
    logic                       weight_ready;
    logic signed [W_WEIGHT-1:0] weight;
    logic                       dout_valid;
    logic                       dout_ready;
    logic signed [W_DOUT-1:0]   dout_data;
    logic                       dout_trunc;
    logic [W_NR-1:0]            dout_nrect;

    modport master (
        output din_valid, din_data, din_last, weight_valid, weight, dout_ready,
        input  din_ready, weight_ready, dout_valid, dout_data, dout_trunc, dout_nrect
    );

    modport slave (
        input  din_valid, din_data, din_last, weight_valid, weight, dout_ready,
        output din_ready, weight_ready, dout_valid, dout_data, dout_trunc, dout_nrect
    );
endinterface

// File: rtl/haar_feature_sum.sv
// Weighted Haar feature summer: 4 corners (+ - + -) per rectangle, one signed weight each,
// up to N_RECT_MAX rectangles summed, scaled by 2^SCALE_SHIFT, output on a registered valid/ready slot.
module haar_feature_sum #(
    parameter int W_DATA      = 18,
    parameter int W_WEIGHT    = 3,
    parameter int N_RECT_MAX  = 3,
    parameter int SCALE_SHIFT = 12
) (
    input logic               clk,
    input logic               rst,
    haar_feature_sum_if.slave bus
);
    localparam int W_NR   = $clog2(N_RECT_MAX + 1);
    localparam int W_ACC  = W_DATA + 2;
    localparam int W_PROD = W_ACC + W_WEIGHT;
    localparam int W_FEAT = W_PROD + W_NR;
    localparam int W_DOUT = W_FEAT + SCALE_SHIFT;

    typedef enum logic [1:0] {CORNER0, CORNER1, CORNER2, CORNER3} corner_e;

    corner_e                    r_corner;
    logic signed [W_ACC-1:0]    r_acc;
    logic signed [W_WEIGHT-1:0] r_weight;
    logic                       r_weight_held;
    logic signed [W_FEAT-1:0]   r_feat;
    logic [W_NR-1:0]            r_rect_cnt;
    logic                       r_dout_valid;
    logic signed [W_DOUT-1:0]   r_dout_data;
    logic                       r_dout_trunc;
    logic [W_NR-1:0]            r_dout_nrect;

    logic                       w_out_free;
    logic                       w_din_ready;
    logic                       w_din_fire;
    logic                       w_wt_fire;
    logic signed [W_ACC-1:0]    w_d;
    logic signed [W_ACC-1:0]    w_rect;
    logic signed [W_PROD-1:0]   w_prod;
    logic signed [W_FEAT-1:0]   w_feat_next;
    logic                       w_rect_end;
    logic                       w_close;
    logic [W_NR-1:0]            w_nrect;

    // Any corner stalls while a result is stuck; corner 3 additionally needs a weight.
    assign w_out_free  = !r_dout_valid || bus.dout_ready;
    assign w_din_ready = ((r_corner != CORNER3) || r_weight_held) && w_out_free;
    assign w_din_fire  = bus.din_valid && w_din_ready;
    assign w_wt_fire   = bus.weight_valid && !r_weight_held;

    assign w_d         = $signed({2'b00, bus.din_data});
    assign w_rect      = r_acc - w_d;
    assign w_prod      = W_PROD'(r_weight) * W_PROD'(w_rect);
    assign w_feat_next = r_feat + W_FEAT'(w_prod);
    assign w_nrect     = r_rect_cnt + W_NR'(1);
    assign w_rect_end  = w_din_fire && (r_corner == CORNER3);
    assign w_close     = w_rect_end && (bus.din_last || (r_rect_cnt == W_NR'(N_RECT_MAX - 1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_corner      <= CORNER0;
            r_acc         <= '0;
            r_weight      <= '0;
            r_weight_held <= 1'b0;
            r_feat        <= '0;
            r_rect_cnt    <= '0;
            r_dout_valid  <= 1'b0;
            r_dout_data   <= '0;
            r_dout_trunc  <= 1'b0;
            r_dout_nrect  <= '0;
        end else begin
            if (w_wt_fire) begin
                r_weight      <= bus.weight;
                r_weight_held <= 1'b1;
            end

            if (w_din_fire) begin
                case (r_corner)
                    CORNER0: begin
                        r_acc    <= w_d;
                        r_corner <= CORNER1;
                    end
                    CORNER1: begin
                        r_acc    <= r_acc - w_d;
                        r_corner <= CORNER2;
                    end
                    CORNER2: begin
                        r_acc    <= r_acc + w_d;
                        r_corner <= CORNER3;
                    end
                    default: begin
                        r_weight_held <= 1'b0;
                        r_corner      <= CORNER0;
                        if (w_close) begin
                            r_feat     <= '0;
                            r_rect_cnt <= '0;
                        end else begin
                            r_feat     <= w_feat_next;
                            r_rect_cnt <= w_nrect;
                        end
                    end
                endcase
            end

            // A close only happens when the slot is free or draining, so loading wins over clearing.
            if (w_close) begin
                r_dout_valid <= 1'b1;
                r_dout_data  <= W_DOUT'(w_feat_next) <<< SCALE_SHIFT;
                r_dout_trunc <= !bus.din_last;
                r_dout_nrect <= w_nrect;
            end else if (r_dout_valid && bus.dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign bus.din_ready    = w_din_ready;
    assign bus.weight_ready = !r_weight_held;
    assign bus.dout_valid   = r_dout_valid;
    assign bus.dout_data    = r_dout_data;
    assign bus.dout_trunc   = r_dout_trunc;
    assign bus.dout_nrect   = r_dout_nrect;
endmodule

// File: tb/tb_haar_feature_sum.sv
// Bench for haar_feature_sum: queue-fed corner/weight drivers, a feature-level reference model,
// and one output monitor that checks every accepted result and output stability under backpressure.
module tb_haar_feature_sum;
    localparam int W_DATA      = 18;
    localparam int W_WEIGHT    = 3;
    localparam int N_RECT_MAX  = 3;
    localparam int SCALE_SHIFT = 12;
    localparam int W_NR        = $clog2(N_RECT_MAX + 1);
    localparam int W_DOUT      = W_DATA + 2 + W_WEIGHT + W_NR + SCALE_SHIFT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    haar_feature_sum_if #(
        .W_DATA(W_DATA), .W_WEIGHT(W_WEIGHT), .N_RECT_MAX(N_RECT_MAX), .SCALE_SHIFT(SCALE_SHIFT)
    ) bus ();

    haar_feature_sum #(
        .W_DATA(W_DATA), .W_WEIGHT(W_WEIGHT), .N_RECT_MAX(N_RECT_MAX), .SCALE_SHIFT(SCALE_SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [W_DATA-1:0] d;
        logic              last;
    } corner_t;

    typedef struct {
        longint data;
        int     nrect;
        bit     trunc;
    } exp_t;

    corner_t                    cq[$];
    logic signed [W_WEIGHT-1:0] wq[$];
    exp_t                       eq[$];

    int     errors = 0;
    int     checks = 0;
    bit     gaps   = 1'b0;
    bit     w_hold = 1'b0;
    int     rdy_mode = 0;
    longint m_sum = 0;
    int     m_n = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a rectangle is w*(c0-c1+c2-c3); a feature closes on last or at N_RECT_MAX.
    task automatic add_rect(input longint c0, input longint c1, input longint c2, input longint c3,
                            input int w, input bit last, input bit junk);
        longint                     cs[4];
        logic signed [W_WEIGHT-1:0] wv;
        corner_t                    c;
        exp_t                       e;
        cs = '{c0, c1, c2, c3};
        wv = W_WEIGHT'(w);
        for (int k = 0; k < 4; k++) begin
            c.d    = W_DATA'(cs[k]);
            c.last = (k == 3) ? last : (junk ? 1'($urandom) : 1'b0);
            cq.push_back(c);
        end
        wq.push_back(wv);
        m_sum += longint'(wv) * (c0 - c1 + c2 - c3);
        m_n++;
        if (last || m_n == N_RECT_MAX) begin
            e.data  = m_sum * (longint'(1) << SCALE_SHIFT);
            e.nrect = m_n;
            e.trunc = !last;
            eq.push_back(e);
            m_sum = 0;
            m_n   = 0;
        end
    endtask

    task automatic push_raw_corner(input longint d);
        corner_t c;
        c.d    = W_DATA'(d);
        c.last = 1'b0;
        cq.push_back(c);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((eq.size() > 0 || cq.size() > 0 || wq.size() > 0 || bus.din_valid || bus.weight_valid)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", eq.size() + cq.size() + wq.size(), 0);
    endtask

    // Inputs change #1 after posedge; handshakes are judged at the preceding negedge.
    initial begin : corner_drv
        corner_t c;
        bit      acc;
        bus.din_valid = 1'b0;
        bus.din_data  = '0;
        bus.din_last  = 1'b0;
        forever begin
            @(negedge clk);
            acc = bus.din_valid && bus.din_ready;
            @(posedge clk);
            #1;
            if (acc || !bus.din_valid) begin
                if (cq.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                    c = cq.pop_front();
                    bus.din_valid = 1'b1;
                    bus.din_data  = c.d;
                    bus.din_last  = c.last;
                end else begin
                    bus.din_valid = 1'b0;
                    bus.din_data  = W_DATA'($urandom);
                    bus.din_last  = 1'($urandom);
                end
            end
        end
    end

    initial begin : weight_drv
        bit acc;
        bus.weight_valid = 1'b0;
        bus.weight       = '0;
        forever begin
            @(negedge clk);
            acc = bus.weight_valid && bus.weight_ready;
            @(posedge clk);
            #1;
            if (acc || !bus.weight_valid) begin
                if (wq.size() > 0 && !w_hold && (!gaps || $urandom_range(0, 3) != 0)) begin
                    bus.weight       = wq.pop_front();
                    bus.weight_valid = 1'b1;
                end else begin
                    bus.weight_valid = 1'b0;
                end
            end
        end
    end

    initial begin : ready_drv
        bus.dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.dout_ready = 1'b1;
                1:       bus.dout_ready = 1'($urandom);
                default: bus.dout_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        exp_t                     e;
        bit                       prev_stall = 1'b0;
        logic signed [W_DOUT-1:0] p_data;
        logic                     p_trunc;
        logic [W_NR-1:0]          p_nrect;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", bus.dout_valid, 1);
                    check("hold_data", bus.dout_data, p_data);
                    check("hold_flags", {bus.dout_trunc, bus.dout_nrect}, {p_trunc, p_nrect});
                end
                if (bus.dout_valid && bus.dout_ready) begin
                    if (eq.size() == 0) begin
                        check("spurious_out", bus.dout_valid, 0);
                    end else begin
                        e = eq.pop_front();
                        check("dout_data", bus.dout_data, e.data);
                        check("dout_nrect", bus.dout_nrect, e.nrect);
                        check("dout_trunc", bus.dout_trunc, e.trunc);
                    end
                end
                prev_stall = bus.dout_valid && !bus.dout_ready;
                p_data     = bus.dout_data;
                p_trunc    = bus.dout_trunc;
                p_nrect    = bus.dout_nrect;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit found;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_data", bus.dout_data, 0);
        check("rst_trunc", bus.dout_trunc, 0);
        check("rst_nrect", bus.dout_nrect, 0);
        check("rst_wready", bus.weight_ready, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single rectangle, with one-cycle latency check
        add_rect(100, 40, 30, 10, -1, 1'b1, 1'b0);
        check("pin_single", eq[$].data, -327680);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (bus.din_valid && bus.din_ready && bus.din_last) found = 1'b1;
        end
        check("last_seen", found, 1);
        check("pre_latency_valid", bus.dout_valid, 0);
        @(negedge clk);
        check("latency_valid", bus.dout_valid, 1);
        wait_drain(200);

        // Two rectangles, weights 2 and 3
        add_rect(100, 40, 30, 10, -1, 1'b0, 1'b0);
        add_rect(50, 20, 20, 10, 2, 1'b1, 1'b0);
        check("pin_two_w2", eq[$].data, 0);
        add_rect(100, 40, 30, 10, -1, 1'b0, 1'b0);
        add_rect(50, 20, 20, 10, 3, 1'b1, 1'b0);
        check("pin_two_w3", eq[$].data, 163840);
        wait_drain(300);

        // Truncation at N_RECT_MAX without din_last
        for (int r = 0; r < 3; r++) add_rect(100, 40, 30, 10, 1, 1'b0, 1'b0);
        check("pin_trunc", eq[$].data, 983040);
        check("pin_trunc_flag", eq[$].trunc, 1);
        wait_drain(300);

        // Weight starvation at corner 3
        w_hold = 1'b1;
        add_rect(100, 40, 30, 10, 1, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (cq.size() == 0 && bus.din_valid) found = 1'b1;
        end
        check("starve_reach_c3", found, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("starve_ready", bus.din_ready, 0);
        end
        w_hold = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.weight_valid && bus.weight_ready) found = 1'b1;
        end
        check("starve_wt_accept", found, 1);
        @(negedge clk);
        check("starve_release", bus.din_ready, 1);
        wait_drain(200);

        // Backpressure with a second feature in flight
        rdy_mode = 2;
        add_rect(100, 40, 30, 10, -1, 1'b1, 1'b0);
        add_rect(50, 20, 20, 10, 3, 1'b0, 1'b0);
        add_rect(100, 40, 30, 10, -1, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.dout_valid) found = 1'b1;
        end
        check("bp_first_valid", found, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_din_ready", bus.din_ready, 0);
        end
        rdy_mode = 0;
        wait_drain(300);

        // Reset after corner 2 of the second rectangle of a feature
        for (int k = 0; k < 4; k++) push_raw_corner(5000 - 1000 * k);
        wq.push_back(W_WEIGHT'(2));
        push_raw_corner(7);
        push_raw_corner(3);
        push_raw_corner(9);
        wq.push_back(W_WEIGHT'(1));
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (cq.size() == 0 && wq.size() == 0 && !bus.din_valid && !bus.weight_valid) found = 1'b1;
        end
        check("partial_sent", found, 1);
        @(negedge clk);
        check("pre_rst_held", bus.weight_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.dout_valid, 0);
        check("mid_rst_data", bus.dout_data, 0);
        check("mid_rst_flags", {bus.dout_trunc, bus.dout_nrect}, 0);
        check("mid_rst_wready", bus.weight_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        add_rect(100, 40, 30, 10, 1, 1'b1, 1'b0);
        wait_drain(200);

        // Randomized features with random gaps and backpressure
        gaps     = 1'b1;
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int nr;
            bit tr;
            nr = $urandom_range(1, N_RECT_MAX);
            tr = (nr == N_RECT_MAX) && ($urandom_range(0, 1) == 1);
            for (int r = 0; r < nr; r++) begin
                add_rect(longint'($urandom_range(0, (1 << W_DATA) - 1)),
                         longint'($urandom_range(0, (1 << W_DATA) - 1)),
                         longint'($urandom_range(0, (1 << W_DATA) - 1)),
                         longint'($urandom_range(0, (1 << W_DATA) - 1)),
                         int'($urandom_range(0, 7)) - 4,
                         (r == nr - 1) && !tr, 1'b1);
            end
        end
        wait_drain(20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
